// File: rtl/parity_serial_rx_if.sv
// rtl/parity_serial_rx_if.sv - received-word bundle between the serial receiver and its consumer
interface parity_serial_rx_if #(
  parameter int N = 8
);
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         parity_error;
  logic         framing_error;
  logic         busy;

  // Receiver side: produces the word and its status pulses
  modport master (
    output data_out,
    output data_valid,
    output parity_error,
    output framing_error,
    output busy
  );

  // Downstream side: consumes the word and its status pulses
  modport slave (
    input data_out,
    input data_valid,
    input parity_error,
    input framing_error,
    input busy
  );
endinterface

// File: rtl/parity_serial_rx.sv
// rtl/parity_serial_rx.sv - serial frame receiver with XOR parity and stop-bit checking
module parity_serial_rx #(
  parameter int N          = 8,
  parameter int BIT_CYCLES = 4,
  parameter int ODD        = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      serial_in,
  parity_serial_rx_if.master        rx
);

  localparam int   CNT_W   = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int   IDX_W   = (N > 2) ? $clog2(N) : 1;
  localparam logic ODD_BIT = (ODD != 0);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t           state, state_n;
  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [N-1:0]     shreg, shreg_n;
  logic             par_acc, par_acc_n;
  logic             bad_par, bad_par_n;
  logic [N-1:0]     dout, dout_n;
  logic             valid, valid_n;
  logic             perr, perr_n;
  logic             ferr, ferr_n;
  logic             s;

  assign s = sync2;

  // Two-flop synchroniser on the asynchronous line; resets to the idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
    end
  end

  // State, counters, assembly registers and registered output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_acc <= 1'b0;
      bad_par <= 1'b0;
      dout    <= '0;
      valid   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      par_acc <= par_acc_n;
      bad_par <= bad_par_n;
      dout    <= dout_n;
      valid   <= valid_n;
      perr    <= perr_n;
      ferr    <= ferr_n;
    end
  end

  // Frame sequencing: mid-bit sampling, LSB-first assembly, parity and stop checks
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shreg_n   = shreg;
    par_acc_n = par_acc;
    bad_par_n = bad_par;
    dout_n    = dout;
    valid_n   = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (!s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end

      START: begin
        // Re-check the line half a bit in so short glitches fall back to IDLE
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (s) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            idx_n     = '0;
            par_acc_n = 1'b0;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n          = '0;
          shreg_n[idx]   = s;
          par_acc_n      = par_acc ^ s;
          if (idx == IDX_LAST) begin
            state_n = PARITY;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          bad_par_n = (s != (par_acc ^ ODD_BIT));
          state_n   = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (s) begin
            dout_n  = shreg;
            valid_n = 1'b1;
            perr_n  = bad_par;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      BREAK: begin
        // A line stuck low must return high before another frame is hunted
        if (s) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign rx.data_out      = dout;
  assign rx.data_valid    = valid;
  assign rx.parity_error  = perr;
  assign rx.framing_error = ferr;
  assign rx.busy          = (state != IDLE);

endmodule

// File: tb/tb_parity_serial_rx.sv
// tb/tb_parity_serial_rx.sv - directed bench for parity_serial_rx (even and odd parity instances)
module tb_parity_serial_rx;

  localparam int N  = 8;
  localparam int BC = 4;

  logic clk;
  logic rst_n;
  logic serial_in;

  int tests;
  int fails;

  parity_serial_rx_if #(.N(N)) ev_if ();
  parity_serial_rx_if #(.N(N)) od_if ();

  parity_serial_rx #(.N(N), .BIT_CYCLES(BC), .ODD(0)) dut_even (
    .clk       (clk),
    .rst_n     (rst_n),
    .serial_in (serial_in),
    .rx        (ev_if)
  );

  parity_serial_rx #(.N(N), .BIT_CYCLES(BC), .ODD(1)) dut_odd (
    .clk       (clk),
    .rst_n     (rst_n),
    .serial_in (serial_in),
    .rx        (od_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge away from the active edge
  int         ev_vcnt, ev_fcnt, ev_stray_perr;
  logic [7:0] ev_last, ev_prev;
  logic       ev_last_perr;
  int         od_vcnt;
  logic [7:0] od_last;
  logic       od_last_perr;

  initial begin
    ev_vcnt = 0; ev_fcnt = 0; ev_stray_perr = 0;
    ev_last = '0; ev_prev = '0; ev_last_perr = 1'b0;
    od_vcnt = 0; od_last = '0; od_last_perr = 1'b0;
  end

  always @(negedge clk) begin
    if (ev_if.data_valid) begin
      ev_vcnt      = ev_vcnt + 1;
      ev_prev      = ev_last;
      ev_last      = ev_if.data_out;
      ev_last_perr = ev_if.parity_error;
    end
    if (ev_if.parity_error && !ev_if.data_valid) ev_stray_perr = ev_stray_perr + 1;
    if (ev_if.framing_error) ev_fcnt = ev_fcnt + 1;
    if (od_if.data_valid) begin
      od_vcnt      = od_vcnt + 1;
      od_last      = od_if.data_out;
      od_last_perr = od_if.parity_error;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    repeat (BC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
  endtask

  task automatic idle_cycles(input int n);
    serial_in = 1'b1;
    repeat (n) @(negedge clk);
    #1;
  endtask

  int v0, f0, o0, sp0;

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;

    // Reset state
    chk("rst_data_out",      32'(ev_if.data_out),      32'h0);
    chk("rst_data_valid",    32'(ev_if.data_valid),    32'h0);
    chk("rst_parity_error",  32'(ev_if.parity_error),  32'h0);
    chk("rst_framing_error", 32'(ev_if.framing_error), 32'h0);
    chk("rst_busy",          32'(ev_if.busy),          32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(4);

    // Good frame 0xA5, even parity 0
    v0 = ev_vcnt; f0 = ev_fcnt; sp0 = ev_stray_perr;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle_cycles(6);
    chk("a5_valid_pulses", 32'(ev_vcnt - v0), 32'd1);
    chk("a5_data",         32'(ev_last),      32'hA5);
    chk("a5_perr",         32'(ev_last_perr), 32'h0);
    chk("a5_ferr_pulses",  32'(ev_fcnt - f0), 32'd0);
    chk("a5_busy_after",   32'(ev_if.busy),   32'h0);
    chk("a5_data_held",    32'(ev_if.data_out), 32'hA5);

    // 0x07 with wrong parity bit 0
    v0 = ev_vcnt;
    send_frame(8'h07, 1'b0, 1'b1);
    idle_cycles(6);
    chk("p07_valid_pulses", 32'(ev_vcnt - v0), 32'd1);
    chk("p07_data",         32'(ev_last),      32'h07);
    chk("p07_perr_with_valid", 32'(ev_last_perr), 32'h1);
    chk("p07_no_stray_perr", 32'(ev_stray_perr - sp0), 32'd0);

    // Framing error: 0x3C, stop bit low, line held low 20 cycles
    v0 = ev_vcnt; f0 = ev_fcnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (16) @(negedge clk);
    #1;
    chk("fe_ferr_pulses",  32'(ev_fcnt - f0),  32'd1);
    chk("fe_no_valid",     32'(ev_vcnt - v0),  32'd0);
    chk("fe_data_kept",    32'(ev_if.data_out), 32'h07);
    chk("fe_busy_in_break", 32'(ev_if.busy),   32'h1);
    idle_cycles(6);
    chk("fe_busy_after_high", 32'(ev_if.busy), 32'h0);
    chk("fe_ferr_still_once", 32'(ev_fcnt - f0), 32'd1);

    // One-cycle glitch while idle
    v0 = ev_vcnt; f0 = ev_fcnt;
    serial_in = 1'b0;
    @(negedge clk);
    idle_cycles(10);
    chk("gl_busy",     32'(ev_if.busy),            32'h0);
    chk("gl_no_pulse", 32'((ev_vcnt - v0) + (ev_fcnt - f0)), 32'd0);

    // Back-to-back frames 0x00 then 0xFF, no idle gap
    v0 = ev_vcnt; sp0 = ev_stray_perr;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle_cycles(6);
    chk("b2b_valid_pulses", 32'(ev_vcnt - v0), 32'd2);
    chk("b2b_first",        32'(ev_prev),      32'h00);
    chk("b2b_second",       32'(ev_last),      32'hFF);
    chk("b2b_perr",         32'(ev_last_perr), 32'h0);

    // Asynchronous reset mid-DATA of 0x55
    v0 = ev_vcnt; f0 = ev_fcnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("mid_busy_before_rst", 32'(ev_if.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ar_data_out", 32'(ev_if.data_out),      32'h0);
    chk("ar_valid",    32'(ev_if.data_valid),    32'h0);
    chk("ar_perr",     32'(ev_if.parity_error),  32'h0);
    chk("ar_ferr",     32'(ev_if.framing_error), 32'h0);
    chk("ar_busy",     32'(ev_if.busy),          32'h0);
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(6);
    chk("ar_no_pulse", 32'((ev_vcnt - v0) + (ev_fcnt - f0)), 32'd0);
    send_frame(8'h81, 1'b0, 1'b1);
    idle_cycles(6);
    chk("ar81_valid_pulses", 32'(ev_vcnt - v0), 32'd1);
    chk("ar81_data",         32'(ev_last),      32'h81);
    chk("ar81_perr",         32'(ev_last_perr), 32'h0);

    // Odd-parity instance: 0xA5 with parity bit 1 (good) then 0 (bad)
    o0 = od_vcnt;
    send_frame(8'hA5, 1'b1, 1'b1);
    idle_cycles(6);
    chk("odd_good_valid", 32'(od_vcnt - o0),  32'd1);
    chk("odd_good_data",  32'(od_last),       32'hA5);
    chk("odd_good_perr",  32'(od_last_perr),  32'h0);
    chk("even_sees_bad",  32'(ev_last_perr),  32'h1);
    o0 = od_vcnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle_cycles(6);
    chk("odd_bad_valid",  32'(od_vcnt - o0),  32'd1);
    chk("odd_bad_perr",   32'(od_last_perr),  32'h1);
    chk("even_sees_good", 32'(ev_last_perr),  32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parity_serial_rx.md
Name: parity_serial_rx

Overview:
- Serial receiver and parity checker: the receive-side counterpart of the team's N-bit XOR parity generator.
- Deserialises an asynchronous frame (start bit, N data bits LSB first, one parity bit, one stop bit) from a single line.
- Recomputes the N-bit XOR parity of the data and flags mismatches.
- Sits at the link input. It presents each received word to downstream logic with a one-cycle valid pulse plus error flags.

Parameters:
- N, 8, data bits per frame (N >= 2).
- BIT_CYCLES, 4, clock cycles per serial bit (even, >= 4).
- ODD, 0, 0 = even parity (parity bit = XOR of data); 1 = odd parity (parity bit = ~XOR of data).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- serial_in  input  1  serial line; idles high, asynchronous to clk.
- data_out  output  N  last received data word; held between frames.
- data_valid  output  1  one-cycle pulse: frame completed with a good stop bit.
- parity_error  output  1  one-cycle pulse, coincident with data_valid, when received parity mismatches computed parity.
- framing_error  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low, async):
  - data_out = 0; data_valid = parity_error = framing_error = 0; busy = 0.
  - State = IDLE; bit counter and cycle counter = 0.
  - Both synchroniser flops = 1 (line idle).
- Reset mid-frame aborts the frame; no output pulse is produced.
- Input path: 2-flop synchroniser; s = second flop. All decisions below use s.
- State machine: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: s==0 -> START, cycle counter cleared.
  - START: counter counts up. At counter == BIT_CYCLES/2-1 (mid start bit), sample s:
    - s==1 -> false start; return to IDLE, no outputs.
    - s==0 -> DATA; counter cleared, bit index = 0.
  - DATA: sample s when counter == BIT_CYCLES-1, then clear counter.
    - Sampled bit goes to shift position bit index (LSB first); running XOR is updated.
    - After bit N-1 -> PARITY.
  - PARITY: sample at BIT_CYCLES-1. Parity is bad if sampled bit != (XOR of data ^ ODD). -> STOP.
  - STOP: sample at BIT_CYCLES-1.
    - s==1: next cycle data_out = assembled word, data_valid = 1, parity_error = bad parity; state -> IDLE.
    - s==0: next cycle framing_error = 1; data_out unchanged; data_valid and parity_error stay 0; state -> BREAK.
  - BREAK: wait for s==1, then -> IDLE. A held-low line never produces repeated frames.
- All pulse outputs are registered, exactly one cycle wide, and deasserted the following cycle.
- Back-to-back frames: a start edge is accepted from the first IDLE cycle after the stop sample.
  - The output pulse cycle and the first IDLE cycle coincide; no frame is lost.
- Latency: the valid pulse asserts 1 cycle after the mid-stop sample.
  - Equivalently, about 2 + BIT_CYCLES/2 + (N+2)*BIT_CYCLES cycles after the start-bit falling edge on serial_in.
- Glitches on serial_in shorter than BIT_CYCLES/2 cycles during IDLE must be rejected by the START mid-bit check.

Test Plan:
- N=8, BIT_CYCLES=4, ODD=0: send 0xA5 (four ones), parity 0, stop 1 -> data_out=0xA5, data_valid 1-cycle pulse, parity_error=0, framing_error=0; busy low afterwards.
- Send 0x07 with parity bit 0 (correct parity is 1) -> data_out=0x07, data_valid=1 and parity_error=1 in the same cycle.
- Send 0x3C with good parity, stop bit 0, line held low 20 cycles then high -> framing_error pulse once, data_out keeps previous value, no data_valid, stays in BREAK (busy=1) until line high, then IDLE.
- serial_in low for 1 cycle while idle -> no state change beyond START, busy returns 0, no pulses. Then two back-to-back frames 0x00 and 0xFF with good parity and no idle gap -> two data_valid pulses, data_out 0x00 then 0xFF.
- rst_n asserted low mid-DATA of frame 0x55 -> all outputs 0 immediately (async). After release, a full frame 0x81 is received correctly with no stale bits.
- ODD=1: send 0xA5 with parity bit 1 -> parity_error=0; same frame with parity bit 0 -> parity_error=1.
